// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg - shared types and constants for the Wishbone RAM arbiter.
//   State encoding, owner encoding, default timeout and timeout counter width.
//   Imported by wb_ram_arbiter and wb_arb_timeout.
package wb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } wb_arb_state_t;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  localparam int TIMEOUT_CYCLES_DEF = 255;
  localparam int TO_CNT_W           = 16;

endpackage

// File: rtl/wb_arb_timeout.sv
// wb_arb_timeout - BUSY watchdog for wb_ram_arbiter.
//   Counts BUSY cycles without a slave ack. Clears whenever the arbiter is
//   not BUSY, so every grant starts from zero.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_busy         arbiter is in BUSY
//   i_ack          owner's transfer is being acked this cycle
//   o_timeout      limit reached and no ack this cycle (ack wins)
module wb_arb_timeout
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_busy,
  input  logic i_ack,
  output logic o_timeout
);

  localparam logic [TO_CNT_W-1:0] LIMIT = TO_CNT_W'(TIMEOUT_CYCLES);

  logic [TO_CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_busy) begin
      r_cnt <= '0;
    end else if (!i_ack && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + TO_CNT_W'(1);
    end
  end

  assign o_timeout = i_busy && (r_cnt == LIMIT) && !i_ack;

endmodule

// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter - two-master to one-slave Wishbone arbiter for the SERV
//   firmware RAM. M0 = SERV CPU bus, M1 = host/SPI loader bridge.
//   Round-robin grant held until slave ack; one idle cycle (stb low) after
//   every transfer.
// Handshake: a master raises stb and holds it (with adr/dat/sel/we stable)
//   until it sees ack or err for one cycle; ack/err are combinational from
//   the slave in the completing cycle and are never both high.
// Optional: define WB_ARB_TIMEOUT_EN to build the BUSY watchdog
//   (wb_arb_timeout); otherwise err outputs are tied low.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_mX_adr/dat/sel/we/stb      master request (X = 0, 1)
//   o_mX_rdt/ack/err             master response
//   o_s_adr/dat/sel/we/stb       slave request
//   i_s_rdt/ack                  slave response
//   o_dbg_state                  current FSM state
module wb_ram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [AW-1:0]   i_m0_adr,
  input  logic [DW-1:0]   i_m0_dat,
  input  logic [DW/8-1:0] i_m0_sel,
  input  logic            i_m0_we,
  input  logic            i_m0_stb,
  output logic [DW-1:0]   o_m0_rdt,
  output logic            o_m0_ack,
  output logic            o_m0_err,
  input  logic [AW-1:0]   i_m1_adr,
  input  logic [DW-1:0]   i_m1_dat,
  input  logic [DW/8-1:0] i_m1_sel,
  input  logic            i_m1_we,
  input  logic            i_m1_stb,
  output logic [DW-1:0]   o_m1_rdt,
  output logic            o_m1_ack,
  output logic            o_m1_err,
  output logic [AW-1:0]   o_s_adr,
  output logic [DW-1:0]   o_s_dat,
  output logic [DW/8-1:0] o_s_sel,
  output logic            o_s_we,
  output logic            o_s_stb,
  input  logic [DW-1:0]   i_s_rdt,
  input  logic            i_s_ack,
  output wb_arb_state_t   o_dbg_state
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("wb_ram_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  wb_arb_state_t r_state;
  logic          r_owner;
  logic          r_last;

  logic w_busy;
  logic w_own_stb;
  logic w_ack;
  logic w_timeout;
  logic w_err;
  logic w_pick;

  assign w_busy    = (r_state == BUSY);
  assign w_own_stb = (r_owner == OWN_M1) ? i_m1_stb : i_m0_stb;
  // Gating with the owner's stb means a late slave ack after the owner
  // abandoned its request is never forwarded.
  assign w_ack     = w_busy & w_own_stb & i_s_ack;
  // On a tie the master that did not win last time is granted.
  assign w_pick    = (i_m0_stb & i_m1_stb) ? ~r_last :
                     (i_m1_stb ? OWN_M1 : OWN_M0);

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_busy    (w_busy),
    .i_ack     (w_ack),
    .o_timeout (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  assign w_err = w_timeout & w_own_stb;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_owner <= OWN_M0;
      r_last  <= OWN_M1;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_m0_stb | i_m1_stb) begin
            r_owner <= w_pick;
            r_last  <= w_pick;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (w_ack | ~w_own_stb | w_timeout) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_s_adr = (r_owner == OWN_M1) ? i_m1_adr : i_m0_adr;
  assign o_s_dat = (r_owner == OWN_M1) ? i_m1_dat : i_m0_dat;
  assign o_s_sel = (r_owner == OWN_M1) ? i_m1_sel : i_m0_sel;
  assign o_s_we  = (r_owner == OWN_M1) ? i_m1_we  : i_m0_we;
  assign o_s_stb = w_busy & w_own_stb & ~w_timeout;

  assign o_m0_ack = w_ack & (r_owner == OWN_M0);
  assign o_m1_ack = w_ack & (r_owner == OWN_M1);
  assign o_m0_err = w_err & (r_owner == OWN_M0);
  assign o_m1_err = w_err & (r_owner == OWN_M1);
  assign o_m0_rdt = o_m0_ack ? i_s_rdt : '0;
  assign o_m1_rdt = o_m1_ack ? i_s_rdt : '0;

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// tb_wb_ram_arbiter - directed bench for wb_ram_arbiter with a behavioural
//   single-cycle-ack RAM (ack one cycle after stb, low the cycle after).
//   Build with WB_ARB_TIMEOUT_EN defined to exercise the watchdog.
module tb_wb_ram_arbiter;
  import wb_arb_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, m0_rdt, m1_rdt;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_stb, m1_we, m1_stb;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] s_adr, s_dat, s_rdt;
  logic [3:0]  s_sel;
  logic        s_we, s_stb, s_ack;
  wb_arb_state_t dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  wb_ram_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_adr(m0_adr), .i_m0_dat(m0_dat), .i_m0_sel(m0_sel), .i_m0_we(m0_we),
    .i_m0_stb(m0_stb), .o_m0_rdt(m0_rdt), .o_m0_ack(m0_ack), .o_m0_err(m0_err),
    .i_m1_adr(m1_adr), .i_m1_dat(m1_dat), .i_m1_sel(m1_sel), .i_m1_we(m1_we),
    .i_m1_stb(m1_stb), .o_m1_rdt(m1_rdt), .o_m1_ack(m1_ack), .o_m1_err(m1_err),
    .o_s_adr(s_adr), .o_s_dat(s_dat), .o_s_sel(s_sel), .o_s_we(s_we),
    .o_s_stb(s_stb), .i_s_rdt(s_rdt), .i_s_ack(s_ack),
    .o_dbg_state(dbg_state)
  );

  // RAM model: not reset by rst (so a late ack can cross a reset); words
  // 0x10 and 0x20 are reloaded while rst is high.
  logic [31:0] mem [0:255];
  logic        ram_mute = 1'b0;
  initial begin
    s_ack = 1'b0;
    s_rdt = '0;
  end
  always @(posedge clk) begin
    if (rst) begin
      mem[8'h10] <= 32'hCAFEBABE;
      mem[8'h20] <= 32'hAABBCCDD;
    end
    if (s_stb && !s_ack && !ram_mute) begin
      for (int b = 0; b < 4; b++)
        if (s_we && s_sel[b]) mem[s_adr[7:0]][8*b +: 8] <= s_dat[8*b +: 8];
      s_rdt <= mem[s_adr[7:0]];
      s_ack <= 1'b1;
    end else begin
      s_ack <= 1'b0;
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    m0_stb = 1'b0;
    m1_stb = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic m0_req(input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic we);
    m0_adr = adr; m0_dat = dat; m0_sel = sel; m0_we = we; m0_stb = 1'b1;
  endtask

  task automatic m1_req(input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic we);
    m1_adr = adr; m1_dat = dat; m1_sel = sel; m1_we = we; m1_stb = 1'b1;
  endtask

  // scoreboard compare
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 1'b0; m0_stb = 1'b0;
    m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 1'b0; m1_stb = 1'b0;
    tick(); tick();

    // reset state
    chk("rst_state", dbg_state, IDLE);
    chk("rst_s_stb", s_stb, 1'b0);
    chk("rst_acks", {m1_ack, m0_ack}, 2'b00);
    chk("rst_errs", {m1_err, m0_err}, 2'b00);
    chk("rst_rdt0", m0_rdt, 32'h0);
    chk("rst_rdt1", m1_rdt, 32'h0);
    rst = 1'b0;

    // single M0 read of 0x10
    m0_req(32'h10, 32'h0, 4'hF, 1'b0);
    tick();
    chk("rd_s_stb_t1", s_stb, 1'b1);
    chk("rd_s_adr_t1", s_adr, 32'h10);
    chk("rd_ack_t1", m0_ack, 1'b0);
    tick();
    chk("rd_ack_t2", m0_ack, 1'b1);
    chk("rd_rdt_t2", m0_rdt, 32'hCAFEBABE);
    chk("rd_m1_ack_t2", m1_ack, 1'b0);
    chk("rd_m1_rdt_t2", m1_rdt, 32'h0);
    m0_stb = 1'b0;
    tick();
    chk("rd_state_t3", dbg_state, IDLE);
    chk("rd_s_stb_t3", s_stb, 1'b0);
    chk("rd_rdt_t3", m0_rdt, 32'h0);

    // simultaneous M0 partial write and M1 read of 0x20
    do_reset();
    m0_req(32'h20, 32'h11223344, 4'b0011, 1'b1);
    m1_req(32'h20, 32'h0, 4'hF, 1'b0);
    tick();
    chk("wr_s_we", s_we, 1'b1);
    chk("wr_s_sel", s_sel, 4'b0011);
    chk("wr_s_dat", s_dat, 32'h11223344);
    tick();
    chk("wr_acks", {m1_ack, m0_ack}, 2'b01);
    m0_stb = 1'b0;
    tick();
    chk("wr_gap_stb", s_stb, 1'b0);
    tick();
    chk("wr_m1_s_stb", s_stb, 1'b1);
    chk("wr_m1_s_we", s_we, 1'b0);
    tick();
    chk("wr_m1_acks", {m1_ack, m0_ack}, 2'b10);
    chk("wr_m1_rdt", m1_rdt, 32'hAABB3344);
    m1_stb = 1'b0;
    tick();

    // both masters requesting continuously for 10 transfers
    do_reset();
    for (int k = 0; k < 10; k++) exp_q.push_back((k % 2 == 0) ? 2'b01 : 2'b10);
    m0_req(32'h10, 32'h0, 4'hF, 1'b0);
    m1_req(32'h20, 32'h0, 4'hF, 1'b0);
    begin
      int n0 = 0;
      int n1 = 0;
      for (int c = 1; c <= 30; c++) begin
        logic [1:0] exp_v;
        tick();
        exp_v = 2'b00;
        if (c % 3 == 2) exp_v = exp_q.pop_front();
        chk($sformatf("rr_acks_c%0d", c), {m1_ack, m0_ack}, exp_v);
        if (m0_ack) n0++;
        if (m1_ack) n1++;
      end
      chk("rr_m0_count", n0, 5);
      chk("rr_m1_count", n1, 5);
      chk("rr_q_left", exp_q.size(), 0);
      chk("rr_end_state", dbg_state, IDLE);
    end
    m0_stb = 1'b0;
    m1_stb = 1'b0;
    tick();

    // M1 arrives while M0 is BUSY, M0 re-requests immediately
    do_reset();
    m0_req(32'h10, 32'h0, 4'hF, 1'b0);
    tick();
    chk("late_s_adr_m0", s_adr, 32'h10);
    m1_req(32'h20, 32'h0, 4'hF, 1'b0);
    tick();
    chk("late_acks_m0", {m1_ack, m0_ack}, 2'b01);
    tick();
    chk("late_gap_stb", s_stb, 1'b0);
    tick();
    chk("late_s_adr_m1", s_adr, 32'h20);
    chk("late_s_stb_m1", s_stb, 1'b1);
    tick();
    chk("late_acks_m1", {m1_ack, m0_ack}, 2'b10);
    chk("late_rdt_m1", m1_rdt, 32'hAABBCCDD);
    m1_stb = 1'b0;
    tick();
    tick();
    chk("late_s_adr_m0b", s_adr, 32'h10);
    tick();
    chk("late_acks_m0b", {m1_ack, m0_ack}, 2'b01);
    m0_stb = 1'b0;
    tick();

    // reset during BUSY, slave ack arrives the cycle after
    m0_req(32'h10, 32'h0, 4'hF, 1'b0);
    tick();
    chk("rb_s_stb", s_stb, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rb_state", dbg_state, IDLE);
    chk("rb_s_stb_after", s_stb, 1'b0);
    chk("rb_acks", {m1_ack, m0_ack}, 2'b00);
    m0_stb = 1'b0;
    tick();

    // owner abandons request without ack
    m0_req(32'h10, 32'h0, 4'hF, 1'b0);
    tick();
    m0_stb = 1'b0;
    #1;
    chk("drop_s_stb", s_stb, 1'b0);
    tick();
    chk("drop_state", dbg_state, IDLE);
    chk("drop_ack", m0_ack, 1'b0);
    tick();
    chk("drop_ack_late", m0_ack, 1'b0);

`ifdef WB_ARB_TIMEOUT_EN
    // slave never acks: M0 errors out, then M1 is served
    do_reset();
    ram_mute = 1'b1;
    m0_req(32'h10, 32'h0, 4'hF, 1'b0);
    tick();
    chk("to_s_stb_c1", s_stb, 1'b1);
    m1_req(32'h20, 32'h0, 4'hF, 1'b0);
    tick(); tick(); tick();
    chk("to_err_c4", {m1_err, m0_err}, 2'b00);
    chk("to_s_stb_c4", s_stb, 1'b1);
    tick();
    chk("to_err_c5", {m1_err, m0_err}, 2'b01);
    chk("to_s_stb_c5", s_stb, 1'b0);
    chk("to_ack_c5", {m1_ack, m0_ack}, 2'b00);
    m0_stb = 1'b0;
    ram_mute = 1'b0;
    tick();
    chk("to_err_c6", {m1_err, m0_err}, 2'b00);
    chk("to_state_c6", dbg_state, IDLE);
    tick();
    chk("to_s_adr_c7", s_adr, 32'h20);
    tick();
    chk("to_m1_ack_c8", {m1_ack, m0_ack}, 2'b10);
    chk("to_m1_rdt_c8", m1_rdt, 32'hAABBCCDD);
    m1_stb = 1'b0;
    tick();
`else
    // without the watchdog BUSY waits indefinitely and err stays low
    do_reset();
    ram_mute = 1'b1;
    m0_req(32'h10, 32'h0, 4'hF, 1'b0);
    repeat (7) tick();
    chk("nto_errs", {m1_err, m0_err}, 2'b00);
    chk("nto_s_stb", s_stb, 1'b1);
    chk("nto_state", dbg_state, BUSY);
    m0_stb = 1'b0;
    tick();
    chk("nto_state_idle", dbg_state, IDLE);
    ram_mute = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
